// File: rtl/muldiv_sequencer_if.sv
// Handshake, result and shared-ALU signals between the core and the mul/div sequencer.
interface muldiv_sequencer_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;

    modport master (
        output start, op, operand_a, operand_b, alu_result,
        input  busy, done, div_by_zero, hi, lo, alu_in1, alu_in2, alu_ctrl
    );

    modport slave (
        input  start, op, operand_a, operand_b, alu_result,
        output busy, done, div_by_zero, hi, lo, alu_in1, alu_in2, alu_ctrl
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULTU (shift-add) / DIVU (restoring) sequencer with HI/LO, time-sharing one external ALU.
//   state  | meaning
//   IDLE   | waiting for start, ALU idle
//   MUL    | one shift-add iteration per cycle
//   DIV    | one restoring-division iteration per cycle
//   DONE   | done pulse, HI/LO final; start may be accepted again
module muldiv_sequencer #(
    parameter int ITER = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    muldiv_sequencer_if.slave   bus
);
    localparam int CW = $clog2(ITER) + 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic           r_busy;
    logic           r_done;
    logic           r_dbz;
    logic [31:0]    r_hi;
    logic [31:0]    r_lo;
    logic [31:0]    r_wh;
    logic [31:0]    r_wl;
    logic [31:0]    r_opd;

    logic           w_accept;
    logic           w_last;
    logic [31:0]    w_rs;
    logic [31:0]    w_alu_in1;
    logic [31:0]    w_alu_in2;
    logic [3:0]     w_alu_ctrl;
    logic           w_carry;
    logic           w_geq;
    logic [31:0]    w_mul_hi;
    logic [31:0]    w_mul_lo;
    logic [31:0]    w_div_hi;
    logic [31:0]    w_div_lo;

    assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_cnt == CW'(ITER - 1));
    assign w_rs     = {r_wh[30:0], r_wl[31]};

    // Working regs are shared: MUL uses {P_hi,P_lo}+multiplicand, DIV uses {R,Q}+divisor.
    always_comb begin
        w_alu_in1  = '0;
        w_alu_in2  = '0;
        w_alu_ctrl = 4'b0000;
        case (r_state)
            S_MUL: begin
                w_alu_ctrl = 4'b0010;
                w_alu_in1  = r_wh;
                w_alu_in2  = r_wl[0] ? r_opd : 32'd0;
            end
            S_DIV: begin
                w_alu_ctrl = 4'b0110;
                w_alu_in1  = w_rs;
                w_alu_in2  = r_opd;
            end
            default: ;
        endcase
    end

    assign w_carry  = (bus.alu_result < w_alu_in1);
    assign w_mul_hi = {w_carry, bus.alu_result[31:1]};
    assign w_mul_lo = {bus.alu_result[0], r_wl[31:1]};

    // The bit shifted out of R is the 33rd remainder bit; if set, Rs certainly exceeds D.
    assign w_geq    = r_wh[31] | (w_rs >= r_opd);
    assign w_div_hi = w_geq ? bus.alu_result : w_rs;
    assign w_div_lo = {r_wl[30:0], w_geq};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_wh    <= '0;
            r_wl    <= '0;
            r_opd   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_state <= S_IDLE;
                    if (w_accept) begin
                        r_dbz <= 1'b0;
                        r_cnt <= '0;
                        case (bus.op)
                            2'b00: begin
                                r_wh    <= '0;
                                r_wl    <= bus.operand_b;
                                r_opd   <= bus.operand_a;
                                r_busy  <= 1'b1;
                                r_state <= S_MUL;
                            end
                            2'b01: begin
                                if (bus.operand_b == 32'd0) begin
                                    r_hi    <= bus.operand_a;
                                    r_lo    <= 32'hFFFF_FFFF;
                                    r_dbz   <= 1'b1;
                                    r_done  <= 1'b1;
                                    r_state <= S_DONE;
                                end else begin
                                    r_wh    <= '0;
                                    r_wl    <= bus.operand_a;
                                    r_opd   <= bus.operand_b;
                                    r_busy  <= 1'b1;
                                    r_state <= S_DIV;
                                end
                            end
                            2'b10: begin
                                r_hi    <= bus.operand_a;
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end
                            default: begin
                                r_lo    <= bus.operand_a;
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end
                        endcase
                    end
                end
                S_MUL: begin
                    r_wh  <= w_mul_hi;
                    r_wl  <= w_mul_lo;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_hi    <= w_mul_hi;
                        r_lo    <= w_mul_lo;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DIV: begin
                    r_wh  <= w_div_hi;
                    r_wl  <= w_div_lo;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_hi    <= w_div_hi;
                        r_lo    <= w_div_lo;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;
    assign bus.alu_in1     = w_alu_in1;
    assign bus.alu_in2     = w_alu_in2;
    assign bus.alu_ctrl    = w_alu_ctrl;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: behavioural ALU plus a HI/LO reference model.
module tb_muldiv_sequencer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_sequencer_if bus();

    muldiv_sequencer #(.ITER(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always_comb begin
        case (bus.alu_ctrl)
            4'b0010: bus.alu_result = bus.alu_in1 + bus.alu_in2;
            4'b0110: bus.alu_result = bus.alu_in1 - bus.alu_in2;
            default: bus.alu_result = 32'd0;
        endcase
    end

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Call at a negedge; returns at the negedge of the first cycle after the start cycle.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] prod;
        e.dbz = 1'b0;
        case (op)
            2'b00: begin
                prod = 64'(a) * 64'(b);
                m_hi = prod[63:32];
                m_lo = prod[31:0];
            end
            2'b01: begin
                if (b == 32'd0) begin
                    m_hi  = a;
                    m_lo  = 32'hFFFF_FFFF;
                    e.dbz = 1'b1;
                end else begin
                    m_hi = a % b;
                    m_lo = a / b;
                end
            end
            2'b10:   m_hi = a;
            default: m_lo = a;
        endcase
        e.hi = m_hi;
        e.lo = m_lo;
        sb.push_back(e);
        bus.start     = 1'b1;
        bus.op        = op;
        bus.operand_a = a;
        bus.operand_b = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input logic div_ctrl, output int n, output int nbusy);
        exp_t e;
        n     = 1;
        nbusy = 0;
        while (!bus.done && n < limit) begin
            if (bus.busy) nbusy++;
            if (div_ctrl && bus.busy) check_val("div_alu_ctrl", 64'(bus.alu_ctrl), 64'(4'b0110));
            @(negedge clk);
            n++;
        end
        check_val("done_seen", 64'(bus.done), 64'd1);
        if (bus.done) begin
            check_val("busy_at_done", 64'(bus.busy), 64'd0);
            check_val("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_val("hi", 64'(bus.hi), 64'(e.hi));
                check_val("lo", 64'(bus.lo), 64'(e.lo));
                check_val("div_by_zero", 64'(bus.div_by_zero), 64'(e.dbz));
            end
        end
    endtask

    initial begin
        int          n;
        int          nb;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        bus.start     = 1'b0;
        bus.op        = 2'b00;
        bus.operand_a = '0;
        bus.operand_b = '0;
        @(negedge clk);
        check_val("rst_busy", 64'(bus.busy), 64'd0);
        check_val("rst_done", 64'(bus.done), 64'd0);
        check_val("rst_dbz", 64'(bus.div_by_zero), 64'd0);
        check_val("rst_hi", 64'(bus.hi), 64'd0);
        check_val("rst_lo", 64'(bus.lo), 64'd0);
        check_val("rst_alu_ctrl", 64'(bus.alu_ctrl), 64'd0);
        check_val("rst_alu_in", {bus.alu_in1, bus.alu_in2}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // MULTU max*max, cycle timing and single-cycle done pulse
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(40, 1'b0, n, nb);
        check_val("mul_done_cycle", 64'(n), 64'd33);
        check_val("mul_busy_cycles", 64'(nb), 64'd32);
        @(negedge clk);
        check_val("done_one_cycle", 64'(bus.done), 64'd0);
        check_val("idle_busy", 64'(bus.busy), 64'd0);

        // DIVU 100/7 with ALU control checked every busy cycle
        issue(2'b01, 32'd100, 32'd7);
        wait_done(40, 1'b1, n, nb);
        check_val("div_done_cycle", 64'(n), 64'd33);
        @(negedge clk);
        check_val("idle_alu_ctrl", 64'(bus.alu_ctrl), 64'd0);

        // divide by zero, then MTLO clears the flag
        issue(2'b01, 32'h1234_5678, 32'd0);
        wait_done(40, 1'b0, n, nb);
        check_val("dbz_done_cycle", 64'(n), 64'd1);
        @(negedge clk);
        check_val("dbz_hold", 64'(bus.div_by_zero), 64'd1);
        issue(2'b11, 32'd5, 32'd0);
        wait_done(40, 1'b0, n, nb);
        check_val("mtlo_done_cycle", 64'(n), 64'd1);

        // MULTU 3x5 with a start pulse at busy cycle 10 that must be ignored
        @(negedge clk);
        issue(2'b00, 32'd3, 32'd5);
        repeat (9) @(negedge clk);
        bus.start     = 1'b1;
        bus.op        = 2'b01;
        bus.operand_a = 32'd9;
        bus.operand_b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(40, 1'b0, n, nb);
        check_val("ignored_nb", 64'(nb), 64'd22);

        // back-to-back DIVU accepted in the DONE cycle
        issue(2'b01, 32'd9, 32'd3);
        check_val("b2b_busy", 64'(bus.busy), 64'd1);
        check_val("b2b_no_done", 64'(bus.done), 64'd0);
        wait_done(40, 1'b1, n, nb);
        check_val("b2b_done_cycle", 64'(n), 64'd33);

        // MTHI
        @(negedge clk);
        issue(2'b10, 32'hDEAD_BEEF, 32'd0);
        check_val("mthi_alu_ctrl", 64'(bus.alu_ctrl), 64'd0);
        wait_done(40, 1'b0, n, nb);
        check_val("mthi_done_cycle", 64'(n), 64'd1);

        // reset at busy cycle 12 aborts the operation
        @(negedge clk);
        issue(2'b00, 32'h0001_0000, 32'h0001_0000);
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("abort_busy", 64'(bus.busy), 64'd0);
        check_val("abort_done", 64'(bus.done), 64'd0);
        check_val("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        check_val("abort_no_done", 64'(bus.done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        issue(2'b00, 32'h0001_0000, 32'h0001_0000);
        wait_done(40, 1'b0, n, nb);
        check_val("post_rst_done_cycle", 64'(n), 64'd33);

        // random MULTU/DIVU
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rop = 2'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = $urandom >> $urandom_range(0, 31);
            if (i == 5) rb = 32'd0;
            issue(rop, ra, rb);
            wait_done(40, rop == 2'b01, n, nb);
            check_val("rand_done_cycle", 64'(n), (rop == 2'b01 && rb == 32'd0) ? 64'd1 : 64'd33);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
